// File: rtl/ddr2_port_arbiter.sv
// Round-robin arbiter sharing the DDR2 controller user port among NPORTS requesters.
// States: IDLE  | waiting for c_rdy and a request; ISSUE | request driven until c_ack;
//         WAIT  | acked, waiting for c_rdy rise;  ABORT | one-cycle watchdog abort.
module ddr2_port_arbiter #(
  parameter int NPORTS  = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NPORTS*26-1:0] p_addr,
  input  logic [NPORTS*64-1:0] p_data_in,
  input  logic [NPORTS-1:0]    p_rd_req,
  input  logic [NPORTS-1:0]    p_wr_req,
  output logic [NPORTS-1:0]    p_ack,
  output logic [NPORTS-1:0]    p_done,
  output logic                 p_err,
  output logic [63:0]          p_data_out,
  output logic [25:0]          c_addr,
  output logic [63:0]          c_data_in,
  output logic                 c_rd_req,
  output logic                 c_wr_req,
  input  logic                 c_ack,
  input  logic                 c_rdy,
  input  logic [63:0]          c_data_out
);

  localparam int GW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int WW = $clog2(TIMEOUT) + 1;
  localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT - 1);
  localparam logic [GW-1:0] LG_RESET = GW'(NPORTS - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ABORT} state_t;

  state_t             state_q, state_d;
  logic [GW-1:0]      last_grant_q, last_grant_d;
  logic [GW-1:0]      grant_q, grant_d;
  logic               grant_wr_q, grant_wr_d;
  logic [WW-1:0]      wd_q, wd_d;
  logic               c_rdy_q;
  logic [NPORTS-1:0]  p_ack_q, p_ack_d;
  logic [NPORTS-1:0]  p_done_q, p_done_d;
  logic               p_err_q, p_err_d;
  logic [63:0]        p_data_out_q, p_data_out_d;
  logic [25:0]        c_addr_q, c_addr_d;
  logic [63:0]        c_data_in_q, c_data_in_d;
  logic               c_rd_req_q, c_rd_req_d;
  logic               c_wr_req_q, c_wr_req_d;

  logic [NPORTS-1:0]  req_any;
  logic               arb_found;
  logic [GW-1:0]      arb_idx;
  logic               arb_wr;
  logic [25:0]        arb_addr;
  logic [63:0]        arb_data;
  logic [NPORTS-1:0]  grant_oh;
  logic               rdy_rise;
  logic               wd_expired;

  assign req_any    = p_rd_req | p_wr_req;
  assign grant_oh   = {{(NPORTS-1){1'b0}}, 1'b1} << grant_q;
  assign rdy_rise   = c_rdy & ~c_rdy_q;
  assign wd_expired = (wd_q >= WD_LAST);

  // Search upward from the port after last_grant; a port holding both ops issues its write.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    arb_wr    = 1'b0;
    arb_addr  = '0;
    arb_data  = '0;
    for (int k = 1; k <= NPORTS; k++) begin
      for (int i = 0; i < NPORTS; i++) begin
        if (!arb_found && req_any[i] && (((int'(last_grant_q) + k) % NPORTS) == i)) begin
          arb_found = 1'b1;
          arb_idx   = GW'(i);
          arb_wr    = p_wr_req[i];
          arb_addr  = p_addr[26*i +: 26];
          arb_data  = p_data_in[64*i +: 64];
        end
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    grant_wr_d   = grant_wr_q;
    wd_d         = wd_q;
    c_addr_d     = c_addr_q;
    c_data_in_d  = c_data_in_q;
    c_rd_req_d   = c_rd_req_q;
    c_wr_req_d   = c_wr_req_q;
    p_ack_d      = '0;
    p_done_d     = '0;
    p_err_d      = 1'b0;
    p_data_out_d = '0;

    case (state_q)
      S_IDLE: begin
        if (c_rdy && arb_found) begin
          grant_d     = arb_idx;
          grant_wr_d  = arb_wr;
          c_addr_d    = arb_addr;
          c_data_in_d = arb_data;
          c_wr_req_d  = arb_wr;
          c_rd_req_d  = ~arb_wr;
          wd_d        = '0;
          state_d     = S_ISSUE;
        end
      end

      S_ISSUE: begin
        wd_d = wd_q + 1'b1;
        // c_ack outranks both a coincident c_rdy rise and watchdog expiry.
        if (c_ack) begin
          c_rd_req_d = 1'b0;
          c_wr_req_d = 1'b0;
          p_ack_d    = grant_oh;
          state_d    = S_WAIT;
        end else if (wd_expired) begin
          c_rd_req_d   = 1'b0;
          c_wr_req_d   = 1'b0;
          p_ack_d      = grant_oh;
          p_done_d     = grant_oh;
          p_err_d      = 1'b1;
          last_grant_d = grant_q;
          state_d      = S_ABORT;
        end
      end

      S_WAIT: begin
        wd_d = wd_q + 1'b1;
        if (rdy_rise) begin
          p_done_d     = grant_oh;
          p_data_out_d = grant_wr_q ? 64'd0 : c_data_out;
          last_grant_d = grant_q;
          state_d      = S_IDLE;
        end else if (wd_expired) begin
          p_done_d     = grant_oh;
          p_err_d      = 1'b1;
          last_grant_d = grant_q;
          state_d      = S_ABORT;
        end
      end

      S_ABORT: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= LG_RESET;
      grant_q      <= '0;
      grant_wr_q   <= 1'b0;
      wd_q         <= '0;
      c_rdy_q      <= 1'b0;
      p_ack_q      <= '0;
      p_done_q     <= '0;
      p_err_q      <= 1'b0;
      p_data_out_q <= '0;
      c_addr_q     <= '0;
      c_data_in_q  <= '0;
      c_rd_req_q   <= 1'b0;
      c_wr_req_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      grant_wr_q   <= grant_wr_d;
      wd_q         <= wd_d;
      c_rdy_q      <= c_rdy;
      p_ack_q      <= p_ack_d;
      p_done_q     <= p_done_d;
      p_err_q      <= p_err_d;
      p_data_out_q <= p_data_out_d;
      c_addr_q     <= c_addr_d;
      c_data_in_q  <= c_data_in_d;
      c_rd_req_q   <= c_rd_req_d;
      c_wr_req_q   <= c_wr_req_d;
    end
  end

  assign p_ack      = p_ack_q;
  assign p_done     = p_done_q;
  assign p_err      = p_err_q;
  assign p_data_out = p_data_out_q;
  assign c_addr     = c_addr_q;
  assign c_data_in  = c_data_in_q;
  assign c_rd_req   = c_rd_req_q;
  assign c_wr_req   = c_wr_req_q;

endmodule
